mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the 4:1 select mux. Four requesters each present a data word with a valid/last handshake. The block grants one requester at a time and drives the registered 2-bit mux select. The grant is held for a whole packet, and the selected lane is forwarded to a single valid/ready output.

Parameters:
DATA_W, 1, width of each data lane and of out_data
MAX_BEATS, 8, beat limit per grant; used only when ARB_HOLD_LIMIT_EN is defined (must be >= 1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
a  input  DATA_W  lane 0 data
b  input  DATA_W  lane 1 data
c  input  DATA_W  lane 2 data
d  input  DATA_W  lane 3 data
req  input  4  per-lane valid; bit i belongs to lane i (a=0 .. d=3)
last  input  4  per-lane end-of-packet, qualified by req[i]
in_ready  output  4  per-lane ready
out_data  output  DATA_W  selected lane data
out_valid  output  1  selected lane valid
out_last  output  1  selected lane last
out_ready  input  1  downstream ready
sel  output  2  registered mux select; s1 = sel[1], s0 = sel[0]
gnt  output  4  registered one-hot grant
busy  output  1  high in GRANT state

Behaviour:
- Reset: rst high asynchronously forces the following, effective immediately and held while rst is high.
  - state = IDLE, sel = 0, gnt = 0, busy = 0, rr pointer ptr = 3 (lane 0 has first priority).
  - All combinational outputs read 0.
- Two-state FSM: IDLE and GRANT.
- Arbitration function:
  - Candidate search order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - The first lane with req set wins.
- IDLE:
  - If req != 0, arbitrate. On the next edge: state = GRANT, sel = winner, gnt = one-hot(winner), busy = 1.
  - Latency: 1 cycle from req rising to gnt.
  - If req == 0, remain in IDLE.
- GRANT, combinational outputs (zero latency from inputs):
  - out_data = lane[sel], out_valid = req[sel], out_last = last[sel].
  - in_ready[sel] = out_ready; all other in_ready bits = 0.
- Transfer (xfer): out_valid & out_ready.
- Release condition, checked in GRANT:
  - (xfer & out_last), or
  - req[sel] == 0, meaning the requester was abandoned. A lane that drops req without last is treated as done.
- On release:
  - ptr = sel on the next edge.
  - Re-arbitrate in the same cycle using the updated order (sel+1 first; the current lane is considered last).
  - For the abandoned case, req[sel] is 0, so the current lane is excluded.
  - If a winner exists: stay in GRANT, load the new sel/gnt on the next edge, no bubble cycle.
  - Otherwise go to IDLE with gnt = 0 and busy = 0. sel keeps its last value.
- Without release, sel/gnt/ptr are held, even while out_ready is low. Backpressure never changes the grant.
- In IDLE: out_valid = 0, out_last = 0, out_data = 0, in_ready = 0.
- req changes on non-granted lanes never disturb the current grant.
- Reset mid-packet: the packet is dropped, and the FSM restarts from IDLE with lane 0 priority.

Optional Feature:
- Macro: ARB_HOLD_LIMIT_EN.
- When defined:
  - A beat counter (width clog2(MAX_BEATS+1)) clears on every new grant and increments on each xfer.
  - When an xfer makes the count reach MAX_BEATS and any other req bit is set, the block forces a release after that beat, even without last.
  - The next owner is chosen by the normal round-robin rule.
  - The preempted lane must re-win arbitration to continue.
  - If no other lane is requesting, the counter saturates and the grant continues.
- When not defined: no counter exists, MAX_BEATS is ignored, and the grant is released only by the conditions in Behaviour.

Test Plan:
- Reset: assert rst with req = 4'b1111 -> gnt = 0, sel = 0, busy = 0 immediately. Deassert rst -> one edge later gnt = 4'b0001, sel = 0.
- Rotation: req = 4'b1111, out_ready = 1, last = 4'b1111 (every packet 1 beat) -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, no idle cycles.
- Packet hold: lane 2 sends 3 beats with last on beat 3 while lanes 0 and 3 request; out_ready toggles 1,0,1,0,1 -> sel stays 2 until the 3rd xfer, then sel = 3.
- Abandon: lane 1 granted, req[1] drops before last with req[0] set -> next edge gnt = 0001; out_valid low during the drop cycle.
- Single requester: only req[3] set, 2-beat packets back-to-back -> sel stays 3, gnt stays 1000 across packets, no bubble.
- ARB_HOLD_LIMIT_EN with MAX_BEATS = 4: lane 0 streams 10 beats with no last while req[1] is set -> release after the 4th xfer and gnt = 0010. Repeat with req[1] = 0 -> all 10 beats go through with no release.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for the 4:1 select mux.
// Grants one of four valid/last requesters for a whole packet. It drives the
// registered mux select and one-hot grant, and forwards the selected lane to a
// single valid/ready output.
// Optional build macro ARB_HOLD_LIMIT_EN: caps a grant at MAX_BEATS beats
// whenever another lane is waiting.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 1,
    parameter int MAX_BEATS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] c,
    input  logic [DATA_W-1:0] d,
    input  logic [3:0]        req,
    input  logic [3:0]        last,
    output logic [3:0]        in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic [1:0]        sel,
    output logic [3:0]        gnt,
    output logic              busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              sel_nxt, ptr, ptr_nxt;
    logic [3:0]              gnt_nxt;
    logic [3:0][DATA_W-1:0]  lane;
    logic                    granted, xfer, rel, force_rel, load;
    logic [2:0]              pick;

    assign lane    = {d, c, b, a};
    assign granted = (state == GRANT);
    assign busy    = granted;

    // Search order is base+1, base+2, base+3, base. The loop runs backwards, so
    // the highest-priority match is assigned last and wins. {found, lane}.
    function automatic logic [2:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = base + 2'(k) + 2'd1;
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Forward the granted lane to the output port; everything reads 0 in IDLE.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        if (granted) begin
            out_data  = lane[sel];
            out_valid = req[sel];
            out_last  = last[sel];
        end
    end

    // Per-lane ready: only the granted lane sees downstream ready.
    for (genvar i = 0; i < 4; i++) begin : g_rdy
        assign in_ready[i] = granted && (sel == 2'(i)) && out_ready;
    end

    assign xfer = out_valid & out_ready;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(MAX_BEATS + 1);
    logic [CW-1:0] cnt;

    // Beats taken under the current grant. Cleared on each new grant, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (xfer && cnt != CW'(MAX_BEATS))
            cnt <= cnt + 1'b1;
    end

    // Preempt after the beat that reaches the limit, but only if someone else
    // is waiting. A lone requester keeps streaming.
    assign force_rel = xfer && (cnt >= CW'(MAX_BEATS - 1)) && |(req & ~gnt);
`else
    assign force_rel = 1'b0;
`endif

    // Abandoning the lane (req dropped) counts as end of packet.
    assign rel  = granted && ((xfer && out_last) || !req[sel] || force_rel);
    // On release, rotate from the current lane so that it is considered last.
    assign pick = rr_pick(rel ? sel : ptr, req);

    // Next-state and next grant: arbitrate from IDLE, or re-arbitrate on release
    // without a bubble cycle.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (pick[2]) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick[1:0];
                    gnt_nxt   = 4'b0001 << pick[1:0];
                    load      = 1'b1;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_nxt = sel;
                    if (pick[2]) begin
                        sel_nxt = pick[1:0];
                        gnt_nxt = 4'b0001 << pick[1:0];
                        load    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, select, grant and rotation pointer. ptr=3 gives lane 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            gnt   <= 4'b0000;
            ptr   <= 2'd3;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule
